// File: rtl/traffic_sink_if.sv
// Ejection-port bundle between a router and the traffic sink: flit channel
// toward the sink, credit return toward the router.
interface traffic_sink_if #(
    parameter int FLIT_W = 32,
    parameter int VC_W   = 2
);
    logic              flit_valid;
    logic [VC_W-1:0]   flit_vc;
    logic [FLIT_W-1:0] flit_data;
    logic              flit_ready;
    logic              credit_valid;
    logic [VC_W-1:0]   credit_vc;

    modport master (
        output flit_valid, flit_vc, flit_data,
        input  flit_ready, credit_valid, credit_vc
    );

    modport slave (
        input  flit_valid, flit_vc, flit_data,
        output flit_ready, credit_valid, credit_vc
    );
endinterface

// File: rtl/traffic_sink.sv
// NoC ejection endpoint: per-VC packet reassembly with framing/destination
// checks, one credit per accepted flit, and packet/flit accounting.
module traffic_sink #(
    parameter int          FLIT_W  = 32,
    parameter int          VC_W    = 2,
    parameter int          NUM_VC  = 4,
    parameter logic [13:0] NODE_ID = 14'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        op,
    input  logic [31:0]       data,
    input  logic              stall,
    traffic_sink_if.slave     ej,
    output logic              pkt_done,
    output logic [VC_W-1:0]   pkt_vc,
    output logic [9:0]        pkt_len,
    output logic [9:0]        pkt_count,
    output logic [15:0]       flit_count,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              done
);
    localparam int            HEAD_B   = FLIT_W - 1;
    localparam int            TAIL_B   = FLIT_W - 2;
    localparam logic [VC_W:0] NUM_VC_L = (VC_W + 1)'(NUM_VC);
    localparam logic [2:0]    OP_INIT  = 3'd5;

    typedef enum logic {IDLE, BUSY} vc_state_e;

    function automatic logic [9:0] sat_inc10(input logic [9:0] x);
        return (x == 10'h3FF) ? x : x + 10'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    logic              armed_q, armed_d;
    logic [9:0]        total_q, total_d;
    vc_state_e         st_q [NUM_VC];
    vc_state_e         st_d [NUM_VC];
    logic [9:0]        len_q [NUM_VC];
    logic [9:0]        len_d [NUM_VC];
    logic              credit_q, credit_d;
    logic [VC_W-1:0]   credit_vc_q, credit_vc_d;
    logic              pkt_done_q, pkt_done_d;
    logic [VC_W-1:0]   pkt_vc_q, pkt_vc_d;
    logic [9:0]        pkt_len_q, pkt_len_d;
    logic [9:0]        pkt_count_q, pkt_count_d;
    logic [15:0]       flit_count_q, flit_count_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              done_q, done_d;

    logic              is_init, accept, is_head, is_tail, dest_ok, vc_ok;
    logic [1:0]        hit_code;
    logic              cmp;
    logic [9:0]        cmp_len;
    logic              unused_ok;

    assign is_init   = (op == OP_INIT);
    assign accept    = ej.flit_valid & ej.flit_ready & ~is_init;
    assign is_head   = ej.flit_data[HEAD_B];
    assign is_tail   = ej.flit_data[TAIL_B];
    assign dest_ok   = (ej.flit_data[29:16] == NODE_ID);
    assign vc_ok     = ({1'b0, ej.flit_vc} < NUM_VC_L);
    assign unused_ok = ^{data[21:0], ej.flit_data[15:0]};

    always_comb begin
        armed_d      = armed_q;
        total_d      = total_q;
        st_d         = st_q;
        len_d        = len_q;
        credit_d     = 1'b0;
        credit_vc_d  = credit_vc_q;
        pkt_done_d   = 1'b0;
        pkt_vc_d     = pkt_vc_q;
        pkt_len_d    = pkt_len_q;
        pkt_count_d  = pkt_count_q;
        flit_count_d = flit_count_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        // done lags the counters by one cycle on purpose
        done_d       = armed_q & (pkt_count_q >= total_q);
        hit_code     = 2'd0;
        cmp          = 1'b0;
        cmp_len      = 10'd0;

        if (is_init) begin
            armed_d      = 1'b1;
            total_d      = data[31:22];
            pkt_count_d  = '0;
            flit_count_d = '0;
            err_d        = 1'b0;
            err_code_d   = 2'd0;
            for (int v = 0; v < NUM_VC; v++) begin
                st_d[v]  = IDLE;
                len_d[v] = '0;
            end
        end else if (accept) begin
            credit_d     = 1'b1;
            credit_vc_d  = ej.flit_vc;
            flit_count_d = sat_inc16(flit_count_q);
            if (!vc_ok) begin
                hit_code = 2'd1;
            end else if (is_head) begin
                // an abandoned open packet outranks a wrong destination
                if (st_q[ej.flit_vc] == BUSY) hit_code = 2'd2;
                else if (!dest_ok)            hit_code = 2'd3;
                if (is_tail) begin
                    st_d[ej.flit_vc] = IDLE;
                    cmp              = 1'b1;
                    cmp_len          = 10'd1;
                end else begin
                    st_d[ej.flit_vc]  = BUSY;
                    len_d[ej.flit_vc] = 10'd1;
                end
            end else if (st_q[ej.flit_vc] == IDLE) begin
                hit_code = 2'd1;
            end else begin
                len_d[ej.flit_vc] = sat_inc10(len_q[ej.flit_vc]);
                if (is_tail) begin
                    st_d[ej.flit_vc] = IDLE;
                    cmp              = 1'b1;
                    cmp_len          = sat_inc10(len_q[ej.flit_vc]);
                end
            end
            if (cmp) begin
                pkt_done_d  = 1'b1;
                pkt_vc_d    = ej.flit_vc;
                pkt_len_d   = cmp_len;
                pkt_count_d = sat_inc10(pkt_count_q);
            end
            if ((hit_code != 2'd0) && !err_q) begin
                err_d      = 1'b1;
                err_code_d = hit_code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed_q      <= 1'b0;
            total_q      <= '0;
            credit_q     <= 1'b0;
            credit_vc_q  <= '0;
            pkt_done_q   <= 1'b0;
            pkt_vc_q     <= '0;
            pkt_len_q    <= '0;
            pkt_count_q  <= '0;
            flit_count_q <= '0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
            done_q       <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) begin
                st_q[v]  <= IDLE;
                len_q[v] <= '0;
            end
        end else begin
            armed_q      <= armed_d;
            total_q      <= total_d;
            credit_q     <= credit_d;
            credit_vc_q  <= credit_vc_d;
            pkt_done_q   <= pkt_done_d;
            pkt_vc_q     <= pkt_vc_d;
            pkt_len_q    <= pkt_len_d;
            pkt_count_q  <= pkt_count_d;
            flit_count_q <= flit_count_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            done_q       <= done_d;
            st_q         <= st_d;
            len_q        <= len_d;
        end
    end

    assign ej.flit_ready   = armed_q & ~stall;
    assign ej.credit_valid = credit_q;
    assign ej.credit_vc    = credit_vc_q;
    assign pkt_done        = pkt_done_q;
    assign pkt_vc          = pkt_vc_q;
    assign pkt_len         = pkt_len_q;
    assign pkt_count       = pkt_count_q;
    assign flit_count      = flit_count_q;
    assign err             = err_q;
    assign err_code        = err_code_q;
    assign done            = done_q;
endmodule

// File: tb/tb_traffic_sink.sv
// Bench for traffic_sink: directed scenarios plus random traffic, all checked
// against a packet-level reference model.
module tb_traffic_sink;
    localparam int NUM_VC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  op;
    logic [31:0] data;
    logic        stall;
    logic        pkt_done;
    logic [1:0]  pkt_vc;
    logic [9:0]  pkt_len;
    logic [9:0]  pkt_count;
    logic [15:0] flit_count;
    logic        err;
    logic [1:0]  err_code;
    logic        done;

    always #5 clk = ~clk;

    traffic_sink_if #(.FLIT_W(32), .VC_W(2)) ej ();

    traffic_sink #(.FLIT_W(32), .VC_W(2), .NUM_VC(NUM_VC), .NODE_ID(14'd0)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .data(data), .stall(stall), .ej(ej),
        .pkt_done(pkt_done), .pkt_vc(pkt_vc), .pkt_len(pkt_len),
        .pkt_count(pkt_count), .flit_count(flit_count),
        .err(err), .err_code(err_code), .done(done)
    );

    int checks   = 0;
    int failures = 0;
    int n_cred   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: per-VC open-packet length (0 = no packet open)
    bit m_armed;
    int m_total, m_pkts, m_flits, m_code;
    int m_open [NUM_VC];
    bit m_err, m_done;
    bit e_credit, e_done;
    int e_credit_vc, e_vc, e_len;

    function automatic void raise(input int c);
        if (!m_err) begin m_err = 1; m_code = c; end
    endfunction

    function automatic void complete(input int v, input int n);
        e_done = 1; e_vc = v; e_len = n;
        m_pkts = (m_pkts < 1023) ? m_pkts + 1 : 1023;
    endfunction

    function automatic void model(input bit r, input logic [2:0] o, input logic [31:0] d,
                                  input bit s, input bit fv, input int vc, input logic [31:0] fd);
        bit nd;
        e_credit = 0; e_done = 0;
        if (r) begin
            m_armed = 0; m_total = 0; m_pkts = 0; m_flits = 0;
            m_err = 0; m_code = 0; m_done = 0;
            e_credit_vc = 0; e_vc = 0; e_len = 0;
            for (int v = 0; v < NUM_VC; v++) m_open[v] = 0;
            return;
        end
        nd = m_armed && (m_pkts >= m_total);
        if (o == 3'd5) begin
            m_armed = 1; m_total = int'(d[31:22]);
            m_pkts = 0; m_flits = 0; m_err = 0; m_code = 0;
            for (int v = 0; v < NUM_VC; v++) m_open[v] = 0;
        end else if (fv && m_armed && !s) begin
            e_credit = 1; e_credit_vc = vc;
            m_flits = (m_flits < 65535) ? m_flits + 1 : 65535;
            if (vc >= NUM_VC) raise(1);
            else if (fd[31]) begin
                if (m_open[vc] > 0) raise(2);
                if (fd[29:16] != 14'd0) raise(3);
                if (fd[30]) begin m_open[vc] = 0; complete(vc, 1); end
                else m_open[vc] = 1;
            end else if (m_open[vc] == 0) raise(1);
            else if (fd[30]) begin
                complete(vc, (m_open[vc] + 1 > 1023) ? 1023 : m_open[vc] + 1);
                m_open[vc] = 0;
            end else m_open[vc] = (m_open[vc] + 1 > 1023) ? 1023 : m_open[vc] + 1;
        end
        m_done = nd;
    endfunction

    function automatic logic [31:0] F(input bit h, input bit t, input int dest, input int pl);
        return {h, t, 14'(dest), 16'(pl)};
    endfunction

    task automatic step(input bit r, input logic [2:0] o, input logic [31:0] d, input bit s,
                        input bit fv, input int vc, input logic [31:0] fd);
        rst_n = !r; op = o; data = d; stall = s;
        ej.flit_valid = fv; ej.flit_vc = 2'(vc); ej.flit_data = fd;
        #1;
        check("flit_ready", ej.flit_ready, m_armed & ~s);
        model(r, o, d, s, fv, vc, fd);
        @(posedge clk); #1;
        if (ej.credit_valid === 1'b1) n_cred++;
        check("credit_valid", ej.credit_valid, e_credit);
        if (e_credit) check("credit_vc", ej.credit_vc, e_credit_vc);
        check("pkt_done", pkt_done, e_done);
        if (e_done) begin
            check("pkt_vc", pkt_vc, e_vc);
            check("pkt_len", pkt_len, e_len);
        end
        check("pkt_count", pkt_count, m_pkts);
        check("flit_count", flit_count, m_flits);
        check("err", err, m_err);
        check("err_code", err_code, m_code);
        check("done", done, m_done);
    endtask

    task automatic idle();
        step(0, 3'd0, 32'd0, 0, 0, 0, 32'd0);
    endtask

    task automatic init(input int tot);
        step(0, 3'd5, {10'(tot), 22'd0}, 0, 0, 0, 32'd0);
        n_cred = 0;
    endtask

    task automatic send(input int vc, input logic [31:0] fd);
        step(0, 3'd0, 32'd0, 0, 1, vc, fd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; op = 0; data = 0; stall = 0;
        ej.flit_valid = 0; ej.flit_vc = 0; ej.flit_data = 0;
        repeat (2) @(posedge clk);
        #1;
        model(1, 3'd0, 32'd0, 0, 0, 0, 32'd0);
        check("rst_ready", ej.flit_ready, 0);
        check("rst_credit", ej.credit_valid, 0);
        check("rst_credit_vc", ej.credit_vc, 0);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_pkt_vc", pkt_vc, 0);
        check("rst_pkt_len", pkt_len, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_flit_count", flit_count, 0);
        check("rst_err", {err, err_code}, 0);
        check("rst_done", done, 0);

        // Three-flit packet on VC1, then a single-flit packet on VC2
        init(2);
        send(1, F(1, 0, 0, 16'h1111));
        send(1, F(0, 0, 0, 16'h2222));
        send(1, F(0, 1, 0, 16'h3333));
        send(2, F(1, 1, 0, 16'h4444));
        idle();
        check("tp1_pkts", pkt_count, 2);
        check("tp1_flits", flit_count, 4);
        check("tp1_credits", n_cred, 4);
        check("tp1_done", done, 1);
        check("tp1_err", err, 0);

        // Interleaved packets on VC0 and VC3
        init(2);
        for (int i = 0; i < 3; i++) begin
            send(0, F(i == 0, i == 2, 0, i));
            send(3, F(i == 0, i == 2, 0, i + 8));
        end
        idle();
        check("tp2_credits", n_cred, 6);
        check("tp2_pkts", pkt_count, 2);
        check("tp2_err", err, 0);

        // Orphan body first, then a re-opened head; first error code sticks
        init(5);
        send(0, F(0, 0, 0, 1));
        send(1, F(1, 0, 0, 2));
        send(1, F(1, 0, 0, 3));
        send(1, F(0, 1, 0, 4));
        check("tp3_err", err, 1);
        check("tp3_code", err_code, 1);
        check("tp3_pkts", pkt_count, 1);
        check("tp3_len", pkt_len, 2);

        // Wrong destination is flagged but still counted
        init(1);
        send(0, F(1, 0, 5, 0));
        send(0, F(0, 1, 0, 0));
        check("tp4_code", err_code, 3);
        check("tp4_pkts", pkt_count, 1);

        // Backpressure holds the flit off
        init(1);
        repeat (3) step(0, 3'd0, 32'd0, 1, 1, 2, F(1, 1, 0, 7));
        check("tp5_stalled_flits", flit_count, 0);
        check("tp5_stalled_credits", n_cred, 0);
        step(0, 3'd0, 32'd0, 0, 1, 2, F(1, 1, 0, 7));
        check("tp5_credit", n_cred, 1);
        idle();

        // Init racing a head, then reset mid-packet
        init(1);
        send(1, F(1, 0, 0, 0));
        step(0, 3'd5, {10'd1, 22'd0}, 0, 1, 1, F(1, 0, 0, 0));
        check("tp6_init_credit", ej.credit_valid, 0);
        check("tp6_init_flits", flit_count, 0);
        send(2, F(1, 0, 0, 0));
        send(2, F(0, 0, 0, 0));
        step(1, 3'd0, 32'd0, 0, 1, 2, F(0, 0, 0, 0));
        check("tp6_rst_credit", ej.credit_valid, 0);
        check("tp6_rst_pkts", pkt_count, 0);
        repeat (2) send(2, F(0, 1, 0, 0));
        check("tp6_rst_ready", ej.flit_ready, 0);
        init(1);
        send(2, F(0, 1, 0, 0));
        check("tp6_orphan_code", err_code, 1);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            bit r, s, fv, h, t;
            logic [2:0] o;
            int dest;
            r    = ($urandom_range(0, 199) == 0);
            o    = ($urandom_range(0, 39) == 0) ? 3'd5 : 3'($urandom_range(0, 4));
            s    = ($urandom_range(0, 3) == 0);
            fv   = ($urandom_range(0, 9) < 7);
            h    = ($urandom_range(0, 9) < 3);
            t    = ($urandom_range(0, 9) < 3);
            dest = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 16383) : 0;
            step(r, o, {10'($urandom_range(0, 6)), 22'($urandom)}, s, fv,
                 $urandom_range(0, NUM_VC - 1), F(h, t, dest, $urandom_range(0, 65535)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
